rom_burst_reader: RTL
=====================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter ADDR_W, default 8: ROM address width; ROM depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 8: ROM word width.
REQ-003 Parameter LEN_W, default 8: burst length counter width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  request a burst; sampled only in IDLE.
REQ-007 abort  in  1  cancel the current burst and flush buffered data.
REQ-008 base_addr  in  ADDR_W  first ROM address, sampled with start.
REQ-009 burst_len  in  LEN_W  number of words, sampled with start.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse on burst completion.
REQ-012 m_data  out  DATA_W  stream data.
REQ-013 m_valid  out  1  stream data valid.
REQ-014 m_ready  in  1  downstream accepts; a beat transfers when m_valid and m_ready are high on a clock edge.
REQ-015 rom_cs  out  1  ROM read strobe (synchronous ROM, 1-cycle latency, address registered at the edge where rom_cs is high).
REQ-016 rom_addr  out  ADDR_W  ROM read address.
REQ-017 rom_dout  in  DATA_W  ROM data, valid in the cycle after the read edge.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH and DRAIN.
REQ-019 IDLE->FETCH on start=1 with burst_len!=0 and abort=0; base_addr and burst_len are latched. start with burst_len=0 is ignored.
REQ-020 The block SHALL issue a read (rom_cs=1, rom_addr=current address) in FETCH when issue count < burst_len and (fifo_count + inflight - pop) < 2; otherwise rom_cs=0, rom_addr holds its last value.
REQ-021 Address SHALL increment by 1 per issued read and wrap from 2^ADDR_W-1 to 0.
REQ-022 Returned rom_dout SHALL be written into a 2-entry output FIFO at the edge after the read edge; m_data/m_valid come from the FIFO head.
REQ-023 Latency: start at edge E0 -> rom_cs high in the cycle after E0 -> m_valid high after edge E2.
REQ-024 With m_ready held at 1, the block SHALL sustain one beat per cycle.
REQ-025 The block SHALL never drop or duplicate a word under any m_ready pattern; m_data stays stable while m_valid=1 and m_ready=0.
REQ-026 FETCH->DRAIN when the last read is issued; DRAIN->IDLE on the edge that transfers the last beat, with done=1 for the following cycle only.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in FETCH or DRAIN has the following effect on the next edge: state returns to IDLE, the FIFO is emptied, and inflight data is discarded. No done is generated. m_valid=0 in the following cycle.
REQ-029 abort and start both high in IDLE: abort wins and no burst starts.
REQ-030 burst_len = 2^LEN_W-1 and bursts crossing address 0 SHALL behave as in REQ-021/024.

Reset
REQ-031 While rst_n=0 the block SHALL be in IDLE, with busy=0, done=0, m_valid=0, m_data=0, rom_cs=0, rom_addr=0, the FIFO empty and all counters at 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst immediately. The first cycle after deassertion SHALL accept start.

Structure
REQ-033 A package rom_burst_pkg SHALL hold the state enum and the ROM_LAT=1 constant.
REQ-034 The 2-entry FIFO SHALL be a sub-module rom_burst_fifo2 (parametrised by DATA_W, providing push, pop, count, head data).
REQ-035 All outputs except rom_cs/rom_addr SHALL be registered; rom_cs/rom_addr are driven from FSM state and counters only, not combinationally from start.

Verification (ADDR_W=LEN_W=DATA_W=8; the ROM model returns addr^8'hA5, 1-cycle latency)
REQ-036 base=8'h10, len=4, m_ready=1 -> beats B5,B4,B7,B6 on 4 consecutive cycles, first m_valid 2 edges after start, then one done pulse.
REQ-037 base=8'hFE, len=4 -> addresses FE,FF,00,01 and data 5B,5A,A5,A4.
REQ-038 len=6 with m_ready toggling 1,0,0,1,... -> all 6 words delivered in order, m_data held while stalled, rom_cs never raised with 2 words buffered.
REQ-039 abort asserted after the 2nd beat of a len=10 burst -> busy=0 next cycle, m_valid=0, no done; a new start (base=0, len=1) returns A5.
REQ-040 rst_n pulsed low mid-burst -> all outputs 0 during reset; start issued right after release succeeds; start with len=0 and start while busy are ignored.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// rtl/rom_burst_pkg.sv - shared types and constants for the ROM burst reader
package rom_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Synchronous ROM read latency in cycles; the inflight tracking assumes 1.
  localparam int ROM_LAT = 1;

endpackage

// File: rtl/rom_burst_fifo2.sv
// rtl/rom_burst_fifo2.sv - two-entry shift FIFO with registered head outputs
module rom_burst_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              pop_ok;

  // Next-state of the two slots: slot 0 is always the head, slot 1 only fills behind it.
  always_comb begin
    d0_d   = d0_q;
    d1_d   = d1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    pop_ok = pop & v0_q;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (pop_ok) begin
      d0_d = d1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
      if (push) begin
        if (v1_q) begin
          d1_d = push_data;
          v1_d = 1'b1;
        end else begin
          d0_d = push_data;
          v0_d = 1'b1;
        end
      end
    end else if (push) begin
      if (!v0_q) begin
        d0_d = push_data;
        v0_d = 1'b1;
      end else begin
        d1_d = push_data;
        v1_d = 1'b1;
      end
    end
  end

  // Slot registers; the head data resets to zero so m_data is clean in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

  assign head_data  = d0_q;
  assign head_valid = v0_q;
  assign count      = {v0_q & v1_q, v0_q ^ v1_q};

endmodule

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - reads a burst of ROM words and streams them out with backpressure
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              pop;
  logic              flush;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              can_issue;

  rom_burst_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (inflight_q),
    .push_data  (rom_dout),
    .pop        (pop),
    .head_data  (m_data),
    .head_valid (m_valid),
    .count      (fifo_count)
  );

  assign pop   = m_valid & m_ready;
  assign flush = abort & (state_q != ST_IDLE);

  // Words already committed (buffered or returning) after this cycle's pop;
  // a new read is only issued if its word is guaranteed a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue = (state_q == ST_FETCH) && (issue_cnt_q < len_q) && (occupancy < 3'd2);

  assign rom_cs   = can_issue;
  assign rom_addr = can_issue ? addr_q : rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Burst sequencing: latch request, issue reads under FIFO credit, finish on the last beat.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rom_addr_d  = rom_addr_q;
    issue_cnt_d = issue_cnt_q;
    len_d       = len_q;
    inflight_d  = can_issue;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort && (burst_len != '0)) begin
          state_d     = ST_FETCH;
          addr_d      = base_addr;
          len_d       = burst_len;
          issue_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (can_issue) begin
          addr_d      = addr_q + 1'b1;
          rom_addr_d  = addr_q;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == len_q - 1'b1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Every read is issued, so a pop with nothing behind it is the last beat.
        if (pop && !inflight_q && (fifo_count == 2'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rom_addr_q  <= '0;
      issue_cnt_q <= '0;
      len_q       <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rom_addr_q  <= rom_addr_d;
      issue_cnt_q <= issue_cnt_d;
      len_q       <= len_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

endmodule
